// File: rtl/cache_types_pkg.sv
// Shared types and geometry for the 2-way write-back L1 cache.
// Line size, set count and tag width all follow from S_OFFSET and S_INDEX.
package cache_types;

  localparam int unsigned S_OFFSET   = 5;
  localparam int unsigned S_INDEX    = 3;
  localparam int unsigned TAG_W      = 32 - S_INDEX - S_OFFSET;
  localparam int unsigned LINE_BYTES = 1 << S_OFFSET;
  localparam int unsigned LINE_W     = 8 * LINE_BYTES;
  localparam int unsigned NUM_SETS   = 1 << S_INDEX;
  localparam int unsigned WORD_W     = S_OFFSET - 2;
  localparam int unsigned LINE_WORDS = LINE_BYTES / 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    WB      = 2'd2,
    FETCH   = 2'd3
  } state_e;

  // Place the 4-bit cpu byte enable at the addressed word of a full line.
  function automatic logic [LINE_BYTES-1:0] line_byte_mask(input logic [WORD_W-1:0] word,
                                                           input logic [3:0]        be);
    logic [LINE_BYTES-1:0] mask;
    mask = '0;
    mask[{word, 2'b00} +: 4] = be;
    return mask;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: tag/valid/dirty/data per set, combinational lookup,
// full-line fill from memory or byte-masked store from the cpu.
module cache_way
  import cache_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [S_INDEX-1:0]    idx_i,
  output logic                  valid_o,
  output logic                  dirty_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic [LINE_W-1:0]     data_o,
  input  logic                  fill_i,
  input  logic [TAG_W-1:0]      fill_tag_i,
  input  logic [LINE_W-1:0]     fill_data_i,
  input  logic                  store_i,
  input  logic [LINE_BYTES-1:0] store_mask_i,
  input  logic [LINE_W-1:0]     store_data_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];
  logic [LINE_W-1:0]   merged_c;

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

  always_comb begin
    merged_c = data_q[idx_i];
    for (int unsigned b = 0; b < LINE_BYTES; b++) begin
      if (store_mask_i[b]) merged_c[b*8 +: 8] = store_data_i[b*8 +: 8];
    end
  end

  // Status bits are reset; a fill always yields a clean line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (store_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_data_i;
    end else if (store_i) begin
      data_q[idx_i] <= merged_c;
    end
  end

endmodule

// File: rtl/l1_cache.sv
// 2-way set-associative write-back, write-allocate L1 cache between the cpu
// word port and a 256-bit line memory; one outstanding request at a time.
module l1_cache
  import cache_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        mem_byte_enable,
  input  logic [31:0]       mem_address,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  state_e              state_q, state_d;
  logic                victim_q, victim_d;
  logic [NUM_SETS-1:0] lru_q, lru_d;

  logic [TAG_W-1:0]    addr_tag;
  logic [S_INDEX-1:0]  addr_idx;
  logic [WORD_W-1:0]   addr_word;
  logic                unused_addr_lsb;

  logic [1:0]          way_valid, way_dirty, way_fill, way_store, hit_vec;
  logic [TAG_W-1:0]    way_tag  [2];
  logic [LINE_W-1:0]   way_data [2];
  logic                hit_c, hit_way_c, victim_c;
  logic [LINE_W-1:0]   hit_line_c, store_line_c;
  logic [LINE_BYTES-1:0] store_mask_c;

  assign addr_tag        = mem_address[31 -: TAG_W];
  assign addr_idx        = mem_address[S_OFFSET +: S_INDEX];
  assign addr_word       = mem_address[2 +: WORD_W];
  assign unused_addr_lsb = ^mem_address[1:0];

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way u_way (
      .clk          (clk),
      .rst          (rst),
      .idx_i        (addr_idx),
      .valid_o      (way_valid[w]),
      .dirty_o      (way_dirty[w]),
      .tag_o        (way_tag[w]),
      .data_o       (way_data[w]),
      .fill_i       (way_fill[w]),
      .fill_tag_i   (addr_tag),
      .fill_data_i  (pmem_rdata),
      .store_i      (way_store[w]),
      .store_mask_i (store_mask_c),
      .store_data_i (store_line_c)
    );
    assign hit_vec[w] = way_valid[w] && (way_tag[w] == addr_tag);
  end

  assign hit_c        = |hit_vec;
  assign hit_way_c    = !hit_vec[0];
  assign hit_line_c   = way_data[hit_way_c];
  assign store_line_c = {LINE_WORDS{mem_wdata}};
  assign store_mask_c = line_byte_mask(addr_word, mem_byte_enable);

  // Prefer an empty way; only evict the LRU way when the set is full.
  always_comb begin
    if (!way_valid[0])      victim_c = 1'b0;
    else if (!way_valid[1]) victim_c = 1'b1;
    else                    victim_c = lru_q[addr_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      lru_q    <= lru_d;
    end
  end

  // Next state and outputs; a simultaneous read+write is handled as a write.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    lru_d        = lru_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    way_fill     = '0;
    way_store    = '0;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit_c) begin
          mem_resp = 1'b1;
          if (mem_write) way_store[hit_way_c] = 1'b1;
          else           mem_rdata = hit_line_c[{addr_word, 5'b0} +: 32];
          lru_d[addr_idx] = !hit_way_c;
          state_d = IDLE;
        end else begin
          victim_d = victim_c;
          state_d  = (way_valid[victim_c] && way_dirty[victim_c]) ? WB : FETCH;
        end
      end
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {way_tag[victim_q], addr_idx, {S_OFFSET{1'b0}}};
        pmem_wdata   = way_data[victim_q];
        if (pmem_resp) state_d = FETCH;
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {addr_tag, addr_idx, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          way_fill[victim_q] = 1'b1;
          state_d = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/l1_cache.md
Name: l1_cache

Overview:
- 2-way set-associative, write-back, write-allocate L1 cache directly downstream of the multicycle rv32i cpu.
- Consumes the cpu memory request port (mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable) and returns mem_rdata/mem_resp.
- Misses and evictions go to physical memory over a 256-bit line interface (pmem_*). One outstanding request at a time.

Parameters:
S_OFFSET, 5, log2 line bytes (32-byte line, 8 words); line width 8*2**S_OFFSET = 256
S_INDEX, 3, log2 sets (8 sets); tag width = 32 - S_INDEX - S_OFFSET = 24

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
mem_read  in  1  cpu read request, held until mem_resp
mem_write  in  1  cpu write request, held until mem_resp
mem_byte_enable  in  4  byte lanes for writes
mem_address  in  32  cpu byte address; bits [1:0] ignored
mem_wdata  in  32  cpu write data
mem_rdata  out  32  read word, valid only while mem_resp=1, else 0
mem_resp  out  1  one-cycle completion pulse
pmem_read  out  1  line fetch request, held until pmem_resp
pmem_write  out  1  line writeback request, held until pmem_resp
pmem_address  out  32  line-aligned address, bits [4:0]=0
pmem_wdata  out  256  victim line data
pmem_rdata  in  256  fetched line
pmem_resp  in  1  memory completion, one cycle

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all valid, dirty, lru bits cleared; mem_resp, pmem_read, pmem_write = 0; mem_rdata, pmem_address, pmem_wdata = 0. Data and tag arrays are not reset.
- Address split: tag = [31:8], index = [7:5], word = [4:2].
- Per set: valid[2], dirty[2], tag[2], data[2], lru (1 bit, names the LRU way). Array lookup is combinational.
- FSM:
  - IDLE: if mem_read|mem_write, go to COMPARE. Both high is a protocol violation; it is treated as a write.
  - COMPARE: hit = valid[w] && tag[w]==addr tag.
    - On a hit, assert mem_resp this cycle. Read: mem_rdata = data[w] word. Write: merge mem_wdata bytes where mem_byte_enable=1 into that word at the clock edge, and set dirty[w]. In both cases lru <= ~w. Go to IDLE.
    - On a miss: victim = way 0 if invalid, else way 1 if invalid, else the lru way. If the victim is valid and dirty, go to WB, else go to FETCH.
  - WB: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line, held stable. On pmem_resp, go to FETCH.
  - FETCH: pmem_read=1, pmem_address={addr tag, index, 5'b0}. On pmem_resp, write pmem_rdata into the victim way, set tag, valid=1, dirty=0, and go to COMPARE, where the access now hits.
- Latency: hit gives mem_resp 2 cycles after the request is first high (IDLE, then COMPARE). Clean miss = 2 + fetch time + 1. Dirty miss adds the writeback time.
- mem_resp is never asserted outside COMPARE. pmem_read and pmem_write are never high together.
- A request still high in IDLE after mem_resp starts a new transaction.
- The cpu request must stay stable from assertion until mem_resp. The cache does not latch it.
- Reset mid-WB/FETCH: pmem strobes drop immediately. The partially handled line is discarded (valid cleared).
- pmem_resp outside WB/FETCH is ignored.

Decomposition:
- Package cache_types: state enum (IDLE, COMPARE, WB, FETCH), derived localparams (TAG_W, LINE_W, NUM_SETS), and a function computing the byte-enable mask for a 32-byte line from word offset and mem_byte_enable.
- Sub-module cache_way, instantiated twice: per-way tag/valid/dirty/data storage with combinational read and write of a full line or byte-masked word. l1_cache holds the lru array, FSM and muxes.

Test Plan:
- Miss: after reset, read 0x0000_0040. Required: pmem_read with pmem_address 0x40, no pmem_write. When the model returns a line with word0=0x1111_0000, mem_resp pulses once with mem_rdata=0x1111_0000.
- Hit: then read 0x0000_0044. Required: mem_resp on the 2nd cycle, no pmem activity, mem_rdata = line word1.
- Byte write: write 0x48, mem_wdata 0xDEADBEEF, mem_byte_enable 4'b0011, with the old word 0x2222_2222. Required: a following read of 0x48 returns 0x2222_BEEF.
- Dirty eviction: with 0x40 dirty and 0x140 then read (same set 2, lru → 0x40's way), read 0x240. Required: pmem_write to 0x40 with the modified line, then pmem_read to 0x240, then mem_resp.
- Slow memory: delay pmem_resp by 10 cycles. Required: pmem_read and pmem_address stable throughout, mem_resp low until completion.
- Reset mid-FETCH: rst=0 while pmem_read=1. Required: pmem_read falls without waiting for clk. After release, a read of the same address misses again.
